// File: rtl/bargraph_switch_decode_pkg.sv
// Shared types and helpers for the slide-switch bar-graph path.
// The display side reuses the decode helpers so both agree on what a valid bar is.
package bargraph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } deb_state_t;

    // 5 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
    localparam int CNT_W_DEFAULT           = 18;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // A thermometer code 2^n-1 has no carry overlap with its own increment.
    function automatic logic is_thermo8(input logic [7:0] v);
        logic [8:0] p;
        p = {1'b0, v} + 9'd1;
        return ((p & {1'b0, v}) == 9'd0);
    endfunction

endpackage

// File: rtl/bargraph_switch_decode_switch_sync.sv
// Per-bit two-flop synchroniser for asynchronous level inputs.
module switch_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/bargraph_switch_decode.sv
// Reads the slide switches as a bar-graph setting: synchronise, debounce,
// then decode to a level with a validity flag and a one-cycle change strobe.
module bargraph_switch_decode
    import bargraph_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic       CCLK,
    input  logic       RSTN,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    input  logic       SW5,
    input  logic       SW6,
    input  logic       SW7,
    output logic [7:0] stable,
    output logic [3:0] level,
    output logic       thermo_ok,
    output logic       update
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sw_raw;
    logic [7:0] sync_vec;

    deb_state_t       state_reg, state_next;
    logic [7:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       stable_reg, stable_next;
    logic [3:0]       level_reg, level_next;
    logic             thermo_reg, thermo_next;
    logic             update_reg, update_next;

    assign sw_raw = {SW7, SW6, SW5, SW4, SW3, SW2, SW1, SW0};

    switch_sync #(
        .W (8)
    ) u_sync (
        .clk   (CCLK),
        .rst_n (RSTN),
        .d     (sw_raw),
        .q     (sync_vec)
    );

    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg  <= ST_IDLE;
            cand_reg   <= 8'h00;
            cnt_reg    <= '0;
            stable_reg <= 8'h00;
            level_reg  <= 4'd0;
            thermo_reg <= 1'b1;
            update_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            level_reg  <= level_next;
            thermo_reg <= thermo_next;
            update_reg <= update_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        level_next  = level_reg;
        thermo_next = thermo_reg;
        update_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sync_vec != stable_reg) begin
                    cand_next  = sync_vec;
                    cnt_next   = '0;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sync_vec != cand_reg) begin
                    // Any bit movement restarts the window; falling back to the
                    // committed value abandons it without a strobe.
                    cnt_next = '0;
                    if (sync_vec == stable_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        cand_next = sync_vec;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_COMMIT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_COMMIT: begin
                // popcount equals n for a 2^n-1 pattern, so one decode serves both cases
                stable_next = cand_reg;
                level_next  = popcount8(cand_reg);
                thermo_next = is_thermo8(cand_reg);
                update_next = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign stable    = stable_reg;
    assign level     = level_reg;
    assign thermo_ok = thermo_reg;
    assign update    = update_reg;

endmodule

// File: tb/tb_bargraph_switch_decode.sv
// Directed bench for bargraph_switch_decode with a run-length reference model
// compared every cycle, plus literal checks on latency and decoded values.
module tb_bargraph_switch_decode;

    localparam int D = 4;

    logic       CCLK;
    logic       RSTN;
    logic [7:0] sw;
    logic [7:0] stable;
    logic [3:0] level;
    logic       thermo_ok;
    logic       update;

    int tests  = 0;
    int fails  = 0;
    int upd_cnt = 0;

    bargraph_switch_decode #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (18)
    ) dut (
        .CCLK      (CCLK),
        .RSTN      (RSTN),
        .SW0       (sw[0]),
        .SW1       (sw[1]),
        .SW2       (sw[2]),
        .SW3       (sw[3]),
        .SW4       (sw[4]),
        .SW5       (sw[5]),
        .SW6       (sw[6]),
        .SW7       (sw[7]),
        .stable    (stable),
        .level     (level),
        .thermo_ok (thermo_ok),
        .update    (update)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    // ---------------- reference model ----------------
    logic [7:0] m_s1, m_s2, m_stable, m_run_val, m_pend_val;
    int         m_run;
    bit         m_pend, m_update;

    function automatic logic [3:0] model_level(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) if (v[i]) c++;
        return 4'(c);
    endfunction

    function automatic bit model_thermo(input logic [7:0] v);
        for (int n = 0; n <= 8; n++) begin
            if ({1'b0, v} == ((9'd1 << n) - 9'd1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // A new value commits once the synchronised input has shown it for D+1
    // consecutive observed edges; the commit edge itself observes nothing.
    always @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00;
            m_run = 0; m_run_val = 8'h00; m_pend = 0; m_pend_val = 8'h00;
            m_update = 0;
        end else begin
            m_update = 0;
            if (m_pend) begin
                m_stable = m_pend_val;
                m_update = 1;
                m_pend   = 0;
                m_run    = 0;
            end else if (m_s2 != m_stable) begin
                if (m_run > 0 && m_s2 == m_run_val) m_run++;
                else begin
                    m_run     = 1;
                    m_run_val = m_s2;
                end
                if (m_run == D + 1) begin
                    m_pend     = 1;
                    m_pend_val = m_s2;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CCLK) begin
        check("cyc_stable", int'(stable), int'(m_stable));
        check("cyc_level", int'(level), int'(model_level(m_stable)));
        check("cyc_thermo", int'(thermo_ok), int'(model_thermo(m_stable)));
        check("cyc_update", int'(update), int'(m_update));
        if (update === 1'b1) upd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    // Counts clock edges from the current SW change until update is seen.
    task automatic measure_latency(input int max_cycles, output int lat);
        lat = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge CCLK);
            #1;
            if (update === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int u0;
        logic [7:0] v;

        RSTN = 1'b0;
        sw   = 8'h00;
        tick(3);
        check("rst_stable", int'(stable), 0);
        check("rst_level", int'(level), 0);
        check("rst_thermo", int'(thermo_ok), 1);
        check("rst_update", int'(update), 0);
        RSTN = 1'b1;
        tick(5);

        // clean step
        u0 = upd_cnt;
        sw = 8'h07;
        measure_latency(20, lat);
        check("step_latency", lat, 8);
        check("step_stable", int'(stable), 8'h07);
        check("step_level", int'(level), 3);
        check("step_thermo", int'(thermo_ok), 1);
        tick(10);
        check("step_updates", upd_cnt - u0, 1);

        // reset in the middle of a settle window
        sw = 8'h0F;
        tick(5);
        #3;
        RSTN = 1'b0;
        #1;
        check("midrst_stable", int'(stable), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_thermo", int'(thermo_ok), 1);
        check("midrst_update", int'(update), 0);
        tick(2);
        RSTN = 1'b1;
        measure_latency(20, lat);
        check("midrst_latency", lat, 8);
        check("midrst_after_stable", int'(stable), 8'h0F);
        check("midrst_after_level", int'(level), 4);

        // non-thermometer pattern, then full bar
        tick(5);
        u0 = upd_cnt;
        sw = 8'hA5;
        measure_latency(20, lat);
        check("a5_latency", lat, 8);
        check("a5_level", int'(level), 4);
        check("a5_thermo", int'(thermo_ok), 0);
        tick(10);
        check("a5_updates", upd_cnt - u0, 1);
        sw = 8'hFF;
        measure_latency(20, lat);
        check("ff_latency", lat, 8);
        check("ff_level", int'(level), 8);
        check("ff_thermo", int'(thermo_ok), 1);
        tick(5);

        // bounce on SW3, then settle on 0x0F
        u0 = upd_cnt;
        for (int i = 0; i < 5; i++) begin
            sw = (i % 2 == 0) ? 8'h07 : 8'h0F;
            tick(2);
        end
        sw = 8'h0F;
        tick(20);
        check("bounce_updates", upd_cnt - u0, 1);
        check("bounce_stable", int'(stable), 8'h0F);
        check("bounce_level", int'(level), 4);

        // glitch that returns before the window expires
        sw = 8'h03;
        tick(12);
        check("glitch_pre_stable", int'(stable), 8'h03);
        u0 = upd_cnt;
        sw = 8'h07;
        tick(3);
        sw = 8'h03;
        tick(20);
        check("glitch_updates", upd_cnt - u0, 0);
        check("glitch_stable", int'(stable), 8'h03);

        // walk all nine thermometer codes
        u0 = upd_cnt;
        for (int n = 0; n <= 8; n++) begin
            v  = 8'((9'd1 << n) - 9'd1);
            sw = v;
            tick(12);
            check("walk_stable", int'(stable), int'(v));
            check("walk_level", int'(level), n);
            check("walk_thermo", int'(thermo_ok), 1);
        end
        check("walk_updates", upd_cnt - u0, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
